// File: rtl/pio_uart_rx_frontend.sv
// 8N1 serial receiver that publishes an atomic status word (data, ferr, seq) for a polled
// read-only PIO input port. Software spots new data by watching seq change.
module pio_uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd,
  output logic [31:0] pio_word,
  output logic        byte_strobe
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t HalfLast = cnt_t'(HALF_BIT - 1);
  localparam cnt_t BitLast  = cnt_t'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q;
  logic       ferr_q;
  logic [7:0] seq_q;
  logic       strobe_q;
  logic       sync1_q, rx_s;
  logic       publish;
  logic       ferr_new;

  // Two-flop synchronizer; idle-high reset so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rx_s    <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    publish   = 1'b0;
    ferr_new  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d    = '0;
          publish  = 1'b1;
          ferr_new = ~rx_s;
          state_d  = rx_s ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // All published fields load on one edge so a poll never sees a torn word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= 8'h00;
      ferr_q   <= 1'b0;
      seq_q    <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= publish;
      if (publish) begin
        data_q <= shift_q;
        ferr_q <= ferr_new;
        seq_q  <= seq_q + 8'd1;
      end
    end
  end

  assign pio_word    = {8'h00, seq_q, 7'h00, ferr_q, data_q};
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_pio_uart_rx_frontend.sv
// Directed bench for pio_uart_rx_frontend at 16 clocks per bit.
module tb_pio_uart_rx_frontend;

  localparam int unsigned Cpb = 16;

  logic        clk;
  logic        reset_n;
  logic        rxd;
  logic [31:0] pio_word;
  logic        byte_strobe;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int fall_cyc = 0;

  pio_uart_rx_frontend #(.CLKS_PER_BIT(Cpb)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .pio_word   (pio_word),
    .byte_strobe(byte_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_strobe === 1'b1) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_strobe_cyc <= cyc;
    end
  end

  // Drive rxd for n cycles; drives land 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(b[i], Cpb);
    hold(stop, Cpb);
  endtask

  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    rxd     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (pio_word !== 32'h0 || byte_strobe !== 1'b0) begin
      $display("FAIL reset_async: word=%h strobe=%b, want 00000000/0", pio_word, byte_strobe);
    end else passed++;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b1, 4);
    @(negedge clk);
    total++;
    if (pio_word !== 32'h0 || byte_strobe !== 1'b0) begin
      $display("FAIL reset_release: word=%h strobe=%b, want 00000000/0", pio_word, byte_strobe);
    end else passed++;
    #1;
  endtask

  task automatic test_single();
    int s0;
    int lat;
    s0 = strobe_cnt;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 8);
    lat = last_strobe_cyc - fall_cyc;
    total++;
    if (pio_word !== 32'h0001_00A5) $display("FAIL single_word: got %h want 000100a5", pio_word);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 1) $display("FAIL single_strobes: got %0d want 1", strobe_cnt - s0);
    else passed++;
    total++;
    if (lat < 154 || lat > 156) $display("FAIL single_latency: got %0d want 154..156", lat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_frame(8'h00, 1'b1);
    total++;
    if (pio_word !== 32'h0001_0000) $display("FAIL b2b_first: got %h want 00010000", pio_word);
    else passed++;
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 8);
    total++;
    if (pio_word !== 32'h0002_00FF) $display("FAIL b2b_second: got %h want 000200ff", pio_word);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 2) $display("FAIL b2b_strobes: got %0d want 2", strobe_cnt - s0);
    else passed++;
  endtask

  task automatic test_glitch();
    int s0;
    s0 = strobe_cnt;
    hold(1'b0, 4);
    hold(1'b1, 40);
    total++;
    if (strobe_cnt - s0 !== 0) $display("FAIL glitch_strobes: got %0d want 0", strobe_cnt - s0);
    else passed++;
    total++;
    if (pio_word !== 32'h0) $display("FAIL glitch_word: got %h want 00000000", pio_word);
    else passed++;
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 8);
    total++;
    if (pio_word !== 32'h0001_003C) $display("FAIL glitch_next: got %h want 0001003c", pio_word);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 1) $display("FAIL glitch_next_strobes: got %0d want 1", strobe_cnt - s0);
    else passed++;
  endtask

  task automatic test_framing();
    int s0;
    send_frame(8'h3C, 1'b0);
    hold(1'b1, 20);
    total++;
    if (pio_word !== 32'h0001_013C) $display("FAIL ferr_word: got %h want 0001013c", pio_word);
    else passed++;
    s0 = strobe_cnt;
    hold(1'b0, 3 * 10 * Cpb);
    total++;
    if (pio_word !== 32'h0002_0100) $display("FAIL break_word: got %h want 00020100", pio_word);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 1) $display("FAIL break_strobes: got %0d want 1", strobe_cnt - s0);
    else passed++;
    hold(1'b1, 20);
    total++;
    if (pio_word !== 32'h0002_0100) $display("FAIL ferr_persist: got %h want 00020100", pio_word);
    else passed++;
    send_frame(8'h11, 1'b1);
    hold(1'b1, 8);
    total++;
    if (pio_word !== 32'h0003_0011) $display("FAIL after_break: got %h want 00030011", pio_word);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    hold(1'b0, Cpb);
    for (int i = 0; i < 4; i++) hold(b[i], Cpb);
    hold(b[4], Cpb / 2);
    reset_n = 1'b0;
    rxd     = 1'b1;
    hold(1'b1, 3);
    reset_n = 1'b1;
    hold(1'b1, 40);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 8);
    total++;
    if (pio_word !== 32'h0001_005A) $display("FAIL mid_reset: got %h want 0001005a", pio_word);
    else passed++;
  endtask

  task automatic test_wrap();
    int s0;
    logic [7:0] b;
    logic [7:0] s;
    s0 = strobe_cnt;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i * 37 + 11);
      s = 8'(i + 2);
      send_frame(b, 1'b1);
      total++;
      if (pio_word !== {8'h00, s, 8'h00, b}) begin
        $display("FAIL wrap_byte%0d: got %h want %h", i, pio_word, {8'h00, s, 8'h00, b});
      end else passed++;
    end
    hold(1'b1, 8);
    total++;
    if (pio_word[31:16] !== 16'h0001) $display("FAIL wrap_seq: got %h want 0001", pio_word[31:16]);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 256) $display("FAIL wrap_strobes: got %0d want 256", strobe_cnt - s0);
    else passed++;
  endtask

  initial begin
    reset_n = 1'b0;
    rxd     = 1'b1;
    #1;
    total++;
    if (pio_word !== 32'h0 || byte_strobe !== 1'b0) begin
      $display("FAIL reset_initial: word=%h strobe=%b, want 00000000/0", pio_word, byte_strobe);
    end else passed++;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b1, 8);

    test_single();
    test_reset();
    test_back_to_back();
    apply_reset();
    test_glitch();
    apply_reset();
    test_framing();
    test_reset_mid_frame();
    test_wrap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
